// File: rtl/result_handshake.sv
// result_handshake: shows a 4-bit classification result to a host and
// holds it until the host has completed a four-phase acknowledge. One
// result can wait in a pending slot. If another result arrives while that
// slot is full, it is dropped and the sticky overrun flag is raised.
module result_handshake (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] answer_in,
    input  logic       layer_3_done,
    input  logic       ack_pin,
    output logic [3:0] result_out,
    output logic       result_valid,
    output logic       result_bad,
    output logic       parity,
    output logic       overrun,
    output logic [7:0] result_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHOW  = 2'd1,
        ACKED = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       ack_meta_q, ack_meta_d;
    logic       ack_s_q, ack_s_d;
    logic       done_q, done_d;
    logic [3:0] disp_q, disp_d;
    logic       pend_valid_q, pend_valid_d;
    logic [3:0] pend_answer_q, pend_answer_d;
    logic       overrun_q, overrun_d;
    logic [7:0] count_q, count_d;
    logic       valid_q, valid_d;
    logic       bad_q, bad_d;
    logic       parity_q, parity_d;
    logic       capture;
    logic       take;

    // Next-state logic: synchroniser, edge detect, display FSM and pending slot.
    always_comb begin
        ack_meta_d    = ack_pin;
        ack_s_d       = ack_meta_q;
        done_d        = layer_3_done;
        state_d       = state_q;
        disp_d        = disp_q;
        pend_valid_d  = pend_valid_q;
        pend_answer_d = pend_answer_q;
        overrun_d     = overrun_q;
        count_d       = count_q;
        capture       = layer_3_done & ~done_q;
        take          = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (capture) begin
                    disp_d  = answer_in;
                    state_d = SHOW;
                    take    = 1'b1;
                end
            end
            SHOW: begin
                if (ack_s_q) begin
                    state_d = ACKED;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            ACKED: begin
                if (!ack_s_q) begin
                    if (pend_valid_q) begin
                        disp_d       = pend_answer_q;
                        pend_valid_d = 1'b0;
                        state_d      = SHOW;
                    end else if (capture) begin
                        disp_d  = answer_in;
                        state_d = SHOW;
                        take    = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        // A capture that did not go straight to the display goes to the
        // pending slot. The check uses the slot state after this cycle's
        // drain, so draining and refilling in the same cycle does not set
        // overrun.
        if (capture && !take) begin
            if (!pend_valid_d) begin
                pend_valid_d  = 1'b1;
                pend_answer_d = answer_in;
            end else begin
                overrun_d = 1'b1;
            end
        end

        valid_d  = (state_d == SHOW);
        bad_d    = (disp_d > 4'd9);
        parity_d = (^disp_d) ^ valid_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            ack_meta_q    <= 1'b0;
            ack_s_q       <= 1'b0;
            done_q        <= 1'b0;
            disp_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_answer_q <= '0;
            overrun_q     <= 1'b0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            bad_q         <= 1'b0;
            parity_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_meta_q    <= ack_meta_d;
            ack_s_q       <= ack_s_d;
            done_q        <= done_d;
            disp_q        <= disp_d;
            pend_valid_q  <= pend_valid_d;
            pend_answer_q <= pend_answer_d;
            overrun_q     <= overrun_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            bad_q         <= bad_d;
            parity_q      <= parity_d;
        end
    end

    assign result_out   = disp_q;
    assign result_valid = valid_q;
    assign result_bad   = bad_q;
    assign parity       = parity_q;
    assign overrun      = overrun_q;
    assign result_count = count_q;

endmodule
